regression_sequencer: RTL and testbench

REGRESSION_SEQUENCER -- requirements
Module: regression_sequencer

---
 rtl/regression_sequencer.sv | 156 +++++++++++++++
 tb/tb_regression_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regression_sequencer.sv
// Control sequencer for a linear-regression datapath: loads N_POINTS samples
// into a shared memory, then runs mean, sum-of-squares and error read passes,
// handshaking with the divider and coefficient units in between.
module regression_sequencer #(
    parameter int N_POINTS = 150,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic              div_done,
    input  logic              coef_done,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic [1:0]        phase,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              div_start,
    output logic              coef_start,
    output logic              err_valid,
    output logic              ready,
    output logic              out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MEAN,
        S_DIV,
        S_SS,
        S_COEF,
        S_ERR,
        S_FIN
    } state_t;

    // Last valid sample address, and the extra drain cycle index of a read pass.
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(N_POINTS - 1);
    localparam logic [ADDR_W-1:0] LP_END  = ADDR_W'(N_POINTS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_first;   // high in the first cycle after any state change

    // State, counter and first-cycle flag registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_first <= (w_state_nxt != r_state);
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        addr        = r_cnt;
        wr_en       = 1'b0;
        phase       = 2'b00;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        div_start   = 1'b0;
        coef_start  = 1'b0;
        err_valid   = 1'b0;
        ready       = 1'b0;
        out_ready   = 1'b0;

        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                end
            end

            S_LOAD: begin
                wr_en = in_valid;
                if (in_valid) begin
                    if (r_cnt == LP_LAST) begin
                        w_state_nxt = S_MEAN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + ADDR_W'(1);
                    end
                end
            end

            S_MEAN, S_SS, S_ERR: begin
                // The drain cycle re-reads the last address while the final
                // read data (one cycle of memory latency) is consumed.
                if (r_cnt == LP_END) begin
                    addr = LP_LAST;
                end
                case (r_state)
                    S_MEAN:  phase = 2'b01;
                    S_SS:    phase = 2'b10;
                    default: phase = 2'b11;
                endcase
                if (r_cnt == '0) begin
                    acc_clr = (r_state != S_ERR);
                end else if (r_state == S_ERR) begin
                    err_valid = 1'b1;
                end else begin
                    acc_en = 1'b1;
                end
                if (r_cnt == LP_END) begin
                    w_cnt_nxt = '0;
                    case (r_state)
                        S_MEAN:  w_state_nxt = S_DIV;
                        S_SS:    w_state_nxt = S_COEF;
                        default: w_state_nxt = S_FIN;
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end

            S_DIV: begin
                // A done coinciding with the start pulse belongs to no request.
                div_start = r_first;
                if (!r_first && div_done) begin
                    w_state_nxt = S_SS;
                    w_cnt_nxt   = '0;
                end
            end

            S_COEF: begin
                coef_start = r_first;
                if (!r_first && coef_done) begin
                    w_state_nxt = S_ERR;
                    w_cnt_nxt   = '0;
                end
            end

            S_FIN: begin
                out_ready   = 1'b1;
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_regression_sequencer.sv
// Directed bench for regression_sequencer (N_POINTS=4): full runs, stalled
// loading, ignored done/start pulses and a mid-pass reset, with a scoreboard
// of expected output events checked every cycle.
module tb_regression_sequencer;

    localparam int NP = 4;
    localparam int AW = 8;

    // Bit positions of each pulse output inside an event word.
    localparam int B_WR = 6;
    localparam int B_CLR = 5;
    localparam int B_EN = 4;
    localparam int B_DS = 3;
    localparam int B_CS = 2;
    localparam int B_EV = 1;
    localparam int B_OR = 0;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, div_done, coef_done;
    logic [AW-1:0] addr;
    logic          wr_en, acc_clr, acc_en, div_start, coef_start, err_valid, ready, out_ready;
    logic [1:0]    phase;

    int            n_checks = 0;
    int            n_fail = 0;
    int            n_or = 0;
    logic [16:0]   sb_q[$];

    always #5 clk = ~clk;

    regression_sequencer #(.N_POINTS(NP), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .div_done(div_done), .coef_done(coef_done), .addr(addr), .wr_en(wr_en),
        .phase(phase), .acc_clr(acc_clr), .acc_en(acc_en), .div_start(div_start),
        .coef_start(coef_start), .err_valid(err_valid), .ready(ready), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] ev(input int b, input logic [1:0] ph, input int a);
        logic [6:0] k;
        k    = '0;
        k[b] = 1'b1;
        return {k, ph, 8'(a)};
    endfunction

    // Compare any pulse activity this cycle against the next expected event.
    task automatic sb_sample();
        logic [6:0]  p;
        logic [16:0] obs;
        p = {wr_en, acc_clr, acc_en, div_start, coef_start, err_valid, out_ready};
        if (p != 7'b0) begin
            if (out_ready) n_or++;
            obs = {p, phase, (wr_en | acc_clr | acc_en | err_valid) ? addr : 8'h0};
            if (sb_q.size() == 0) check("sb_extra_event", 32'(obs), 32'h0);
            else check("sb_event", 32'(obs), 32'(sb_q.pop_front()));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
        sb_sample();
    endtask

    task automatic begin_run();
        cyc();
        start = 1'b1; in_valid = 1'b0; div_done = 1'b0; coef_done = 1'b0;
        settle();
        check("idle_ready", ready, 1);
        check("idle_phase", phase, 0);
    endtask

    task automatic load(input logic [15:0] pat, input int len);
        int w;
        w = 0;
        for (int i = 0; i < len; i++) begin
            cyc();
            start = 1'b0; in_valid = pat[i];
            if (pat[i]) sb_q.push_back(ev(B_WR, 2'b00, w));
            settle();
            check("load_wr_en", wr_en, pat[i]);
            check("load_addr", addr, w);
            check("load_ready", ready, 0);
            check("load_phase", phase, 0);
            if (pat[i]) w++;
        end
    endtask

    task automatic read_pass(input logic [1:0] ph, input int ncyc, input int inj_div,
                             input int inj_start, input int rst_at);
        int a;
        for (int k = 0; k < ncyc; k++) begin
            cyc();
            in_valid = 1'b0; coef_done = 1'b0;
            div_done = (k == inj_div);
            start    = (k == inj_start);
            reset    = (k == rst_at);
            a = (k < NP) ? k : NP - 1;
            if (ph == 2'b11) begin
                if (k > 0) sb_q.push_back(ev(B_EV, ph, a));
            end else begin
                sb_q.push_back(ev((k == 0) ? B_CLR : B_EN, ph, a));
            end
            settle();
            check("pass_phase", phase, ph);
            check("pass_addr", addr, a);
            check("pass_acc_clr", acc_clr, (ph != 2'b11) && (k == 0));
            check("pass_acc_en", acc_en, (ph != 2'b11) && (k > 0));
            check("pass_err_valid", err_valid, (ph == 2'b11) && (k > 0));
        end
    endtask

    task automatic handshake(input bit is_coef, input int delay, input bit inj_first);
        logic d;
        for (int k = 0; k <= delay; k++) begin
            cyc();
            start = 1'b0;
            d = (k == delay) || ((k == 0) && inj_first);
            div_done  = is_coef ? 1'b0 : d;
            coef_done = is_coef ? d : 1'b0;
            if (k == 0) sb_q.push_back(ev(is_coef ? B_CS : B_DS, 2'b00, 0));
            settle();
            check("hs_phase", phase, 0);
            check("hs_ready", ready, 0);
            check("hs_start_pulse", is_coef ? coef_start : div_start, k == 0);
            check("hs_other_start", is_coef ? div_start : coef_start, 0);
        end
    endtask

    task automatic fin();
        cyc();
        start = 1'b0; div_done = 1'b0; coef_done = 1'b0;
        sb_q.push_back(ev(B_OR, 2'b00, 0));
        settle();
        check("fin_out_ready", out_ready, 1);
        check("fin_phase", phase, 0);
        check("fin_ready", ready, 0);
        cyc();
        settle();
        check("post_ready", ready, 1);
        check("post_out_ready", out_ready, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; div_done = 1'b0; coef_done = 1'b0;
        repeat (2) @(posedge clk);
        // Reset state, with start held high to confirm reset priority.
        cyc();
        start = 1'b1;
        settle();
        check("rst_ready", ready, 1);
        check("rst_addr", addr, 0);
        check("rst_phase", phase, 0);
        check("rst_pulses", {wr_en, acc_clr, acc_en, div_start, coef_start, err_valid, out_ready}, 0);
        reset = 1'b0; start = 1'b0;

        // Run 1: stalled load, done during MEAN and on the start-pulse cycles,
        // start pulsed during ERR.
        begin_run();
        load(16'h0059, 7);
        read_pass(2'b01, NP + 1, 2, -1, -1);
        handshake(1'b0, 3, 1'b1);
        read_pass(2'b10, NP + 1, -1, -1, -1);
        handshake(1'b1, 5, 1'b1);
        read_pass(2'b11, NP + 1, -1, 2, -1);
        fin();

        // Run 2: continuous load, nominal handshake latencies.
        begin_run();
        load(16'h000F, 4);
        read_pass(2'b01, NP + 1, -1, -1, -1);
        handshake(1'b0, 3, 1'b0);
        read_pass(2'b10, NP + 1, -1, -1, -1);
        handshake(1'b1, 5, 1'b0);
        read_pass(2'b11, NP + 1, -1, -1, -1);
        fin();

        // Run 3: reset asserted in SS while addr=2, start held high throughout.
        begin_run();
        load(16'h000F, 4);
        read_pass(2'b01, NP + 1, -1, -1, -1);
        handshake(1'b0, 3, 1'b0);
        read_pass(2'b10, 3, -1, 2, 2);
        cyc();
        reset = 1'b1; start = 1'b1;
        settle();
        check("midrst_ready", ready, 1);
        check("midrst_addr", addr, 0);
        check("midrst_phase", phase, 0);
        check("midrst_acc_en", acc_en, 0);
        cyc();
        reset = 1'b0; start = 1'b1;
        settle();
        check("rst_prio_ready", ready, 1);
        check("rst_prio_phase", phase, 0);

        // Run 4: started by the held start once reset is low.
        load(16'h000F, 4);
        read_pass(2'b01, NP + 1, -1, -1, -1);
        handshake(1'b0, 3, 1'b0);
        read_pass(2'b10, NP + 1, -1, -1, -1);
        handshake(1'b1, 5, 1'b0);
        read_pass(2'b11, NP + 1, -1, -1, -1);
        fin();

        repeat (3) begin
            cyc();
            settle();
        end
        check("sb_drained", sb_q.size(), 0);
        check("out_ready_count", n_or, 3);
        check("final_ready", ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
